// File: rtl/tpu_isa_pkg.sv
// TPU instruction-set constants shared by the issue front end: opcodes,
// field positions, the NOP word and the decoded instruction layout.
package tpu_isa_pkg;

    localparam int unsigned INSTR_W  = 32;
    localparam int unsigned OP_W     = 8;
    localparam int unsigned REG_W    = 4;
    localparam int unsigned NUM_REGS = 16;
    localparam int unsigned SB_CNT_W = 4;

    localparam int unsigned OP_MSB = 31;
    localparam int unsigned OP_LSB = 24;
    localparam int unsigned RA_MSB = 23;
    localparam int unsigned RA_LSB = 20;
    localparam int unsigned RB_MSB = 19;
    localparam int unsigned RB_LSB = 16;
    localparam int unsigned RC_MSB = 15;
    localparam int unsigned RC_LSB = 12;

    localparam logic [OP_W-1:0] OP_NOP            = 8'h00;
    localparam logic [OP_W-1:0] OP_LOAD           = 8'h01;
    localparam logic [OP_W-1:0] OP_STORE          = 8'h02;
    localparam logic [OP_W-1:0] OP_MMU_FP16       = 8'h03;
    localparam logic [OP_W-1:0] OP_MMU_INT8       = 8'h04;
    localparam logic [OP_W-1:0] OP_RELU           = 8'h05;
    localparam logic [OP_W-1:0] OP_ADD            = 8'h06;
    localparam logic [OP_W-1:0] OP_SOFTMAX        = 8'h07;
    localparam logic [OP_W-1:0] OP_DMA            = 8'h10;
    localparam logic [OP_W-1:0] OP_SG             = 8'h11;
    localparam logic [OP_W-1:0] OP_CONV           = 8'h20;
    localparam logic [OP_W-1:0] OP_ATTN           = 8'h21;
    localparam logic [OP_W-1:0] OP_FUSE_MMA_RELU  = 8'h30;
    localparam logic [OP_W-1:0] OP_FUSE_CONV_RELU = 8'h31;

    localparam logic [INSTR_W-1:0] NOP_WORD = 32'h0000_0000;

    // Field order matches the bit positions above: op, A, B, C, unused tail.
    typedef struct packed {
        logic [OP_W-1:0]  op;
        logic [REG_W-1:0] reg_a;
        logic [REG_W-1:0] reg_b;
        logic [REG_W-1:0] reg_c;
        logic [11:0]      rsvd;
    } instr_t;

    function automatic instr_t decode_instr(input logic [INSTR_W-1:0] word);
        return instr_t'(word);
    endfunction

endpackage

// File: rtl/tpu_instr_fifo.sv
// Show-ahead instruction FIFO: head is visible whenever the queue is
// non-empty; flush empties it and discards a same-cycle push.
module tpu_instr_fifo
    import tpu_isa_pkg::*;
#(
    parameter int unsigned DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [INSTR_W-1:0]         push_data,
    input  logic                       pop,
    input  logic                       flush,
    output logic                       full_c,
    output logic                       head_valid_c,
    output logic [INSTR_W-1:0]         head_c,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [INSTR_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic               push_ok;
    logic               pop_ok;

    // A full FIFO refuses pushes even when a pop frees a slot this cycle.
    assign full_c       = (count == CNT_W'(DEPTH));
    assign head_valid_c = (count != '0);
    assign head_c       = mem[rd_ptr];
    assign push_ok      = push && !full_c && !flush;
    assign pop_ok       = pop && head_valid_c && !flush;

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers are PTR_W wide, so they wrap modulo DEPTH on their own.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/tpu_issue_ctrl.sv
// Issue controller for the forwarding-less 5-stage TPU pipeline: queues
// instructions and inserts NOP bubbles until RAW sources have written back.
module tpu_issue_ctrl
    import tpu_isa_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH    = 8,
    parameter int unsigned HAZARD_WINDOW = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [INSTR_W-1:0]            in_instr,
    input  logic                          hold,
    input  logic                          flush,
    output logic [INSTR_W-1:0]            issue_instr,
    output logic                          issue_fire,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic [NUM_REGS-1:0]           busy_mask,
    output logic [31:0]                   stall_count
);

    localparam logic [SB_CNT_W-1:0] SB_LOAD = SB_CNT_W'(HAZARD_WINDOW - 1);

    logic                 fifo_full_c;
    logic                 head_valid_c;
    logic [INSTR_W-1:0]   head_c;
    instr_t               head_f;
    logic                 head_is_nop_c;
    logic                 hazard_c;
    logic                 issue_c;
    logic                 stall_c;
    logic                 load_c;
    logic [NUM_REGS-1:0]  busy_c;
    logic [SB_CNT_W-1:0]  sb_cnt [NUM_REGS];

    tpu_instr_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk          (clk),
        .rst          (rst),
        .push         (in_valid),
        .push_data    (in_instr),
        .pop          (issue_c),
        .flush        (flush),
        .full_c       (fifo_full_c),
        .head_valid_c (head_valid_c),
        .head_c       (head_c),
        .count        (fifo_count)
    );

    assign in_ready = !fifo_full_c;

    always_comb begin
        busy_c = '0;
        for (int r = 0; r < NUM_REGS; r++) begin
            busy_c[r] = (sb_cnt[r] != '0);
        end
    end

    assign busy_mask = busy_c;

    // Only older in-flight writers are visible in the scoreboard, so an
    // instruction that reads its own destination never blocks itself.
    assign head_f        = decode_instr(head_c);
    assign head_is_nop_c = (head_f.op == OP_NOP);
    assign hazard_c      = !head_is_nop_c && (busy_c[head_f.reg_a] || busy_c[head_f.reg_b]);
    assign issue_c       = head_valid_c && !hold && !flush && !hazard_c;
    assign stall_c       = head_valid_c && !hold && !flush && hazard_c;
    assign load_c        = issue_c && !head_is_nop_c;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            issue_instr <= NOP_WORD;
            issue_fire  <= 1'b0;
        end else if (issue_c) begin
            issue_instr <= head_is_nop_c ? NOP_WORD : head_c;
            issue_fire  <= 1'b1;
        end else begin
            issue_instr <= NOP_WORD;
            issue_fire  <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_count <= '0;
        end else if (stall_c && (stall_count != '1)) begin
            stall_count <= stall_count + 32'd1;
        end
    end

    // Counters free-run through hold and flush: in-flight writes still land.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                sb_cnt[r] <= '0;
            end
        end else begin
            for (int r = 0; r < NUM_REGS; r++) begin
                if (load_c && (head_f.reg_c == REG_W'(r))) begin
                    sb_cnt[r] <= SB_LOAD;
                end else if (sb_cnt[r] != '0) begin
                    sb_cnt[r] <= sb_cnt[r] - SB_CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_tpu_issue_ctrl.sv
// Self-checking bench for tpu_issue_ctrl: table of two-instruction pairs
// plus hand sequences for fill/hold, flush and mid-operation reset.
module tb_tpu_issue_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_instr = 32'h0;
    logic        hold = 1'b0;
    logic        flush = 1'b0;
    logic [31:0] issue_instr;
    logic        issue_fire;
    logic [3:0]  fifo_count;
    logic [15:0] busy_mask;
    logic [31:0] stall_count;

    int n_checks = 0;
    int n_pass   = 0;
    logic [31:0] sb[$];

    always #5 clk = ~clk;

    tpu_issue_ctrl #(
        .FIFO_DEPTH    (8),
        .HAZARD_WINDOW (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_instr    (in_instr),
        .hold        (hold),
        .flush       (flush),
        .issue_instr (issue_instr),
        .issue_fire  (issue_fire),
        .fifo_count  (fifo_count),
        .busy_mask   (busy_mask),
        .stall_count (stall_count)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual=0x%08h required=0x%08h", name, act, exp);
    endtask

    // One cycle: record the accepted push in the scoreboard, then step past the edge.
    task automatic tick();
        if (in_valid && in_ready && !flush)
            sb.push_back((in_instr[31:24] == 8'h00) ? 32'h0 : in_instr);
        if (flush) sb.delete();
        @(posedge clk);
        #1;
    endtask

    // Every issued instruction must be the oldest accepted, un-flushed one.
    always @(posedge clk) begin
        #1;
        if (!rst && issue_fire) begin
            if (sb.size() == 0) begin
                n_checks++;
                $display("FAIL issue_unexpected: actual=0x%08h required=no issue", issue_instr);
            end else begin
                check("issue_order", issue_instr, sb.pop_front());
            end
        end
    end

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        int          watch;
        int          gap;
        int          stalls;
        int          busy;
    } vec_t;

    vec_t vecs[8];

    initial begin
        int exp_stall_total;
        int nf, nb, first, second, fires;

        vecs[0] = '{32'h06123000, 32'h06456000, 3, 1, 0, 3};
        vecs[1] = '{32'h06123000, 32'h05340000, 3, 4, 3, 3};
        vecs[2] = '{32'h06123000, 32'h05430000, 3, 4, 3, 3};
        vecs[3] = '{32'h06123000, 32'h06003000, 3, 1, 0, 4};
        vecs[4] = '{32'h00003000, 32'h05340000, 3, 1, 0, 0};
        vecs[5] = '{32'h06333000, 32'h06111000, 3, 1, 0, 3};
        vecs[6] = '{32'h07567000, 32'h06070000, 7, 4, 3, 3};
        vecs[7] = '{32'h00123000, 32'h06334000, 3, 1, 0, 0};

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_issue_instr", issue_instr, 32'h0);
        check("rst_issue_fire", 32'(issue_fire), 32'h0);
        check("rst_fifo_count", 32'(fifo_count), 32'h0);
        check("rst_busy_mask", 32'(busy_mask), 32'h0);
        check("rst_stall_count", stall_count, 32'h0);
        check("rst_in_ready", 32'(in_ready), 32'h1);
        #3 rst = 1'b0;
        @(posedge clk);
        #1;

        // Table: two back-to-back pushes, measure issue gap, stalls and busy time
        exp_stall_total = 0;
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1;
            in_instr = vecs[i].a;
            tick();
            in_instr = vecs[i].b;
            tick();
            in_valid = 1'b0;
            nf = 0; nb = 0; first = -1; second = -1;
            for (int c = 0; c < 16; c++) begin
                if (issue_fire) begin
                    if (nf == 0) first = c;
                    else if (nf == 1) second = c;
                    nf++;
                end
                if (busy_mask[vecs[i].watch]) nb++;
                if (c != 15) tick();
            end
            exp_stall_total += vecs[i].stalls;
            check($sformatf("v%0d_fires", i), 32'(nf), 32'd2);
            check($sformatf("v%0d_gap", i), 32'(second - first), 32'(vecs[i].gap));
            check($sformatf("v%0d_busy_cycles", i), 32'(nb), 32'(vecs[i].busy));
            check($sformatf("v%0d_stall_count", i), stall_count, 32'(exp_stall_total));
        end

        // Fill under hold: ninth push refused, then drain in order
        hold = 1'b1;
        for (int i = 0; i < 9; i++) begin
            in_valid = 1'b1;
            in_instr = 32'h06000000 | (32'(i + 1) << 12);
            if (i == 8) check("full_in_ready", 32'(in_ready), 32'h0);
            tick();
        end
        check("full_fifo_count", 32'(fifo_count), 32'd8);
        check("hold_no_fire", 32'(issue_fire), 32'h0);
        hold = 1'b0;
        tick();
        fires = issue_fire ? 1 : 0;
        check("full_push_pop_count", 32'(fifo_count), 32'd7);
        tick();
        fires += issue_fire ? 1 : 0;
        check("push_pop_count", 32'(fifo_count), 32'd7);
        in_valid = 1'b0;
        for (int c = 0; c < 10; c++) begin
            tick();
            fires += issue_fire ? 1 : 0;
        end
        check("drain_fires", 32'(fires), 32'd9);
        check("drain_fifo_count", 32'(fifo_count), 32'h0);
        check("drain_in_ready", 32'(in_ready), 32'h1);

        // Flush with a hazard pending on r3 and five dependents queued
        hold = 1'b1;
        in_valid = 1'b1;
        in_instr = 32'h06123000;
        tick();
        in_instr = 32'h05340000;
        repeat (5) tick();
        check("flush_pre_count", 32'(fifo_count), 32'd6);
        hold = 1'b0;
        in_valid = 1'b0;
        tick();
        check("flush_producer_count", 32'(fifo_count), 32'd5);
        check("flush_busy0", 32'(busy_mask[3]), 32'h1);
        flush = 1'b1;
        in_valid = 1'b1;
        in_instr = 32'h06abc000;
        check("flush_in_ready", 32'(in_ready), 32'h1);
        tick();
        flush = 1'b0;
        in_valid = 1'b0;
        check("flush_fifo_count", 32'(fifo_count), 32'h0);
        check("flush_fire", 32'(issue_fire), 32'h0);
        check("flush_busy1", 32'(busy_mask[3]), 32'h1);
        tick();
        check("flush_busy2", 32'(busy_mask[3]), 32'h1);
        tick();
        check("flush_busy3", 32'(busy_mask[3]), 32'h0);
        fires = 0;
        repeat (6) begin
            tick();
            fires += issue_fire ? 1 : 0;
        end
        check("flush_no_issue", 32'(fires), 32'h0);
        check("flush_stall_count", stall_count, 32'(exp_stall_total));

        // Asynchronous reset with four queued and r3 busy
        hold = 1'b1;
        in_valid = 1'b1;
        in_instr = 32'h06123000;
        tick();
        in_instr = 32'h05340000;
        repeat (4) tick();
        hold = 1'b0;
        in_valid = 1'b0;
        tick();
        check("prerst_issue", issue_instr, 32'h06123000);
        check("prerst_count", 32'(fifo_count), 32'd4);
        check("prerst_busy3", 32'(busy_mask[3]), 32'h1);
        #2 rst = 1'b1;
        #1;
        sb.delete();
        check("arst_issue_instr", issue_instr, 32'h0);
        check("arst_issue_fire", 32'(issue_fire), 32'h0);
        check("arst_fifo_count", 32'(fifo_count), 32'h0);
        check("arst_busy_mask", 32'(busy_mask), 32'h0);
        check("arst_stall_count", stall_count, 32'h0);
        @(posedge clk);
        #1 rst = 1'b0;
        fires = 0;
        repeat (6) begin
            tick();
            fires += issue_fire ? 1 : 0;
        end
        check("postrst_no_issue", 32'(fires), 32'h0);
        check("postrst_fifo_count", 32'(fifo_count), 32'h0);
        check("sb_empty", 32'(sb.size()), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/tpu_issue_ctrl.md
Name: tpu_issue_ctrl

Overview:
- Instruction issue controller in front of the 5-stage TPU pipeline (IF/ID/EX/MEM/WB).
- Buffers incoming instructions in a FIFO and tracks pending register writes in a per-register scoreboard.
- Releases one instruction per cycle into the pipeline's instruction input, inserting NOP (0x00000000) bubbles on read-after-write hazards, because the pipeline has no forwarding.

Parameters:
- FIFO_DEPTH, 8, instruction queue entries; power of two, ≥2.
- HAZARD_WINDOW, 4, cycles from a producer's issue edge until a dependent instruction may issue. Range 1..15.
- NUM_REGS, 16, architectural registers; fixed by the 4-bit register fields.

Ports:
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-high
- in_valid  in  1  upstream instruction valid
- in_ready  out  1  FIFO can accept an instruction; combinational `!full`
- in_instr  in  32  instruction word: opcode [31:24], regA [23:20], regB [19:16], regC [15:12], [11:0] ignored
- hold  in  1  downstream pause; while 1, only NOPs are issued
- flush  in  1  synchronous discard of all queued, not-yet-issued instructions
- issue_instr  out  32  registered instruction to the pipeline instruction input; NOP when nothing issues
- issue_fire  out  1  registered; 1 in the cycle `issue_instr` holds a real dequeued instruction
- fifo_count  out  $clog2(FIFO_DEPTH)+1  current queue occupancy
- busy_mask  out  NUM_REGS  bit r = scoreboard counter r is nonzero
- stall_count  out  32  cycles in which the head was valid but blocked by a hazard; saturates at 0xFFFFFFFF

Behaviour:
- Reset values: FIFO empty, `issue_instr`=0, `issue_fire`=0, all scoreboard counters 0, `stall_count`=0. Reset mid-operation drops all queued instructions; no partial issue.
- Push: occurs when `in_valid && in_ready`.
  - `in_ready` is 0 when `fifo_count==FIFO_DEPTH`.
  - A push into a full FIFO is not accepted, even if a pop happens in the same cycle.
- Head decode: opcode `op`, sources A and B, destination C.
- hazard = `(op!=0) && (cnt[A]!=0 || cnt[B]!=0)`.
  - A NOP at the head (`op==0`) is never hazarded. It is popped and issued as 0, with `issue_fire`=1.
- Issue condition: `head_valid && !hold && !flush && !hazard`. On the edge where it holds:
  - `issue_instr` <= head; `issue_fire` <= 1; head is popped.
  - If `op!=0`: `cnt[C]` <= HAZARD_WINDOW-1. This overrides that register's decrement in the same cycle.
- When the issue condition is false: `issue_instr` <= 0 and `issue_fire` <= 0.
- `stall_count` increments when `head_valid && !hold && !flush && hazard`.
- Scoreboard: each cycle, every counter not being loaded decrements toward 0, saturating at 0.
- Timing consequence: a dependent instruction issues no earlier than HAZARD_WINDOW edges after its producer. With the default of 4, back-to-back dependents get exactly 3 NOP bubbles.
- Independent instructions issue back-to-back, at 1 per cycle.
- WAW needs no check: the pipeline is in-order with fixed latency.
- flush:
  - Empties the FIFO and forces an issued NOP that cycle.
  - Scoreboard counters keep counting, because instructions already in flight still write back.
  - A push in the same cycle as flush is discarded; `in_ready` stays asserted.
- hold:
  - Counters keep decrementing, since the pipeline free-runs.
  - Pushes are still accepted.
- Simultaneous push and pop on a non-full FIFO: `fifo_count` is unchanged.
- FIFO pointers wrap modulo FIFO_DEPTH.
- Self-dependency (`C==A` or `C==B`) is checked only against older instructions. An instruction never blocks itself.

Decomposition:
- Shared package `tpu_isa_pkg`:
  - opcode constants: NOP=0x00, LOAD=0x01, STORE=0x02, MMU_FP16=0x03, MMU_INT8=0x04, RELU=0x05, ADD=0x06, SOFTMAX=0x07, DMA=0x10, SG=0x11, CONV=0x20, ATTN=0x21, FUSE_MMA_RELU=0x30, FUSE_CONV_RELU=0x31
  - instruction field bit positions
  - NOP word constant
- Sub-module `tpu_instr_fifo`: synchronous FIFO with push, pop, flush, count, head output and show-ahead read.
- Scoreboard and issue logic stay in `tpu_issue_ctrl`.

Test Plan:
- Reset, then push independent ADDs 0x06123000 and 0x06456000 -> both issue on consecutive edges; `issue_fire`=1,1; `stall_count`=0.
- Push 0x06123000 (writes r3), then 0x05340000 (reads r3) -> second instruction issues 4 edges after the first; 3 NOP cycles between; `stall_count`=3; `busy_mask[3]` high for 3 cycles.
- Push 9 instructions with `hold`=1 -> `in_ready` falls after 8 pushes; `fifo_count`=8. Release `hold` -> 8 issues in order, then `in_ready` returns to 1.
- Hazard pending on r3, assert `flush` for 1 cycle with 5 queued -> `fifo_count`=0 next cycle; `busy_mask[3]` still clears on schedule; no queued instruction is ever issued.
- Assert `rst` while 4 instructions are queued and `busy_mask`≠0 -> immediately `issue_instr`=0, `fifo_count`=0, `busy_mask`=0, `stall_count`=0.
- Push NOP 0x00000000, then 0x06334000 (reads r3, writes r4) -> NOP issues and marks nothing; ADD issues on the next edge with no stall.
